// File: rtl/sixteen_segment_scan_driver_pkg.sv
// Glyph table and segment indices for the 16-segment scan driver.
// Bit order [15:0] = a,b,c,d,e,f,g,h,k,m,n,u,p,t,s,r; glyph bits are active-low (0 = lit).
package sixteen_segment_pkg;

  localparam int SEG_SLOTS = 16;

  localparam int SEG_A = 15;
  localparam int SEG_B = 14;
  localparam int SEG_C = 13;
  localparam int SEG_D = 12;
  localparam int SEG_E = 11;
  localparam int SEG_F = 10;
  localparam int SEG_G = 9;
  localparam int SEG_H = 8;
  localparam int SEG_K = 7;
  localparam int SEG_M = 6;
  localparam int SEG_N = 5;
  localparam int SEG_U = 4;
  localparam int SEG_P = 3;
  localparam int SEG_T = 2;
  localparam int SEG_S = 1;
  localparam int SEG_R = 0;

  // a,b top; c,d right; e,f bottom; g,h left; u,p middle bar halves
  localparam logic [15:0] GLYPH [16] = '{
    16'h00FF, 16'hCFFF, 16'h11E7, 16'h03E7,
    16'hCEE7, 16'h22E7, 16'h20E7, 16'h0FFF,
    16'h00E7, 16'h02E7, 16'h0CE7, 16'hE0E7,
    16'h30FF, 16'hC1E7, 16'h30E7, 16'h3CEF
  };

endpackage

// File: rtl/sixteen_segment_scan_driver_if.sv
// Display bus between measurement logic (master) and the scan driver (slave).
// dp_in exists only when SIXTEEN_SEG_DP_EN is defined.
interface sixteen_segment_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_enable;
`ifdef SIXTEEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
`endif
  logic [15:0]             segment_n;
  logic                    segment_dp_n;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_start;

`ifdef SIXTEEN_SEG_DP_EN
  modport master (output value, digit_enable, dp_in,
                  input  segment_n, segment_dp_n, anode, frame_start);
  modport slave  (input  value, digit_enable, dp_in,
                  output segment_n, segment_dp_n, anode, frame_start);
`else
  modport master (output value, digit_enable,
                  input  segment_n, segment_dp_n, anode, frame_start);
  modport slave  (input  value, digit_enable,
                  output segment_n, segment_dp_n, anode, frame_start);
`endif
endinterface

// File: rtl/sixteen_segment_scan_driver_tick_divider.sv
// Free-running prescaler: tick is high for one CLK while the count sits at DIVIDE-1.
// tick is registered by decoding DIVIDE-2 one cycle early.
module tick_divider #(
  parameter int DIVIDE = 8192
) (
  input  logic CLK,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  logic [CW-1:0] count_r;
  logic          tick_r;

  // prescaler count and early-decoded terminal-count flag
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      if (count_r == CW'(DIVIDE - 1)) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + 1'b1;
      end
      tick_r <= (count_r == CW'(DIVIDE - 2));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/sixteen_segment_scan_driver.sv
// Scans NUM_DIGITS common-anode 16-segment digits, one cathode lit at a time.
// Optional decimal-point slot enabled by defining SIXTEEN_SEG_DP_EN.
module sixteen_segment_scan_driver
  import sixteen_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DOT_DIVIDE   = 8192,
  parameter int BLANK_CYCLES = 0
) (
  input logic                          CLK,
  input logic                          reset_n,
  sixteen_segment_scan_driver_if.slave disp
);
`ifdef SIXTEEN_SEG_DP_EN
  localparam int NUM_SLOTS = SEG_SLOTS + 1;
`else
  localparam int NUM_SLOTS = SEG_SLOTS;
`endif
  localparam int SLOT_W   = 5;
  localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLANK_W  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam bit BLANK_EN = (BLANK_CYCLES > 0);

  logic                    dot_tick_s;
  logic                    slot_wrap_s;
  logic                    digit_wrap_s;
  logic [SLOT_W-1:0]       slot_r, slot_next_s;
  logic [DIG_W-1:0]        digit_r, digit_next_s;
  logic [4*NUM_DIGITS-1:0] snap_value_r, snap_value_next_s;
  logic [NUM_DIGITS-1:0]   snap_enable_r, snap_enable_next_s;
  logic [NUM_DIGITS-1:0]   snap_dp_s, snap_dp_next_s;
  logic [NUM_DIGITS-1:0]   anode_next_s;
  logic [BLANK_W-1:0]      blank_cnt_r;
  logic [15:0]             segment_n_r;
  logic                    segment_dp_n_r;
  logic [NUM_DIGITS-1:0]   anode_r;
  logic                    frame_start_r;
  logic [16:0]             tick_pat_s;
  logic [16:0]             hold_pat_s;

  tick_divider #(.DIVIDE(DOT_DIVIDE)) u_tick_divider (
    .CLK     (CLK),
    .reset_n (reset_n),
    .tick    (dot_tick_s)
  );

  // {dp_n, segment_n} for one slot of one digit: at most one bit low
  function automatic logic [16:0] slot_pattern(
    input logic [SLOT_W-1:0]       slot,
    input logic [DIG_W-1:0]        digit,
    input logic [4*NUM_DIGITS-1:0] val,
    input logic [NUM_DIGITS-1:0]   en,
    input logic [NUM_DIGITS-1:0]   dp
  );
    logic [15:0]           seg;
    logic                  dpn;
    logic [3:0]            nyb;
    logic [3:0]            bit_idx;
    logic [NUM_DIGITS-1:0] sel;
    seg     = 16'hFFFF;
    dpn     = 1'b1;
    nyb     = 4'(val >> (4 * digit));
    bit_idx = 4'd15 - slot[3:0];
    sel     = NUM_DIGITS'(1) << digit;
    if (|(en & sel)) begin
      if (slot < SLOT_W'(SEG_SLOTS)) begin
        seg[bit_idx] = GLYPH[nyb][bit_idx];
      end else begin
        dpn = ~(|(dp & sel));
      end
    end else begin
      seg = 16'hFFFF;
    end
    return {dpn, seg};
  endfunction

  assign slot_wrap_s  = dot_tick_s && (slot_r == SLOT_W'(NUM_SLOTS - 1));
  assign digit_wrap_s = slot_wrap_s && (digit_r == DIG_W'(NUM_DIGITS - 1));

  // next slot/digit and frame-wrap snapshot of the inputs
  always_comb begin
    slot_next_s        = slot_r;
    digit_next_s       = digit_r;
    snap_value_next_s  = snap_value_r;
    snap_enable_next_s = snap_enable_r;
    snap_dp_next_s     = snap_dp_s;
    if (slot_wrap_s) begin
      slot_next_s = '0;
    end else if (dot_tick_s) begin
      slot_next_s = slot_r + 1'b1;
    end else begin
      slot_next_s = slot_r;
    end
    if (digit_wrap_s) begin
      digit_next_s       = '0;
      snap_value_next_s  = disp.value;
      snap_enable_next_s = disp.digit_enable;
`ifdef SIXTEEN_SEG_DP_EN
      snap_dp_next_s     = disp.dp_in;
`else
      snap_dp_next_s     = '0;
`endif
    end else if (slot_wrap_s) begin
      digit_next_s = digit_r + 1'b1;
    end else begin
      digit_next_s = digit_r;
    end
  end

  assign anode_next_s = NUM_DIGITS'(1) << digit_next_s;
  assign tick_pat_s   = slot_pattern(slot_next_s, digit_next_s, snap_value_next_s,
                                     snap_enable_next_s, snap_dp_next_s);
  assign hold_pat_s   = slot_pattern(slot_r, digit_r, snap_value_r, snap_enable_r, snap_dp_s);

  // scan position and snapshot registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      slot_r        <= '0;
      digit_r       <= '0;
      snap_value_r  <= '0;
      snap_enable_r <= '0;
    end else begin
      slot_r        <= slot_next_s;
      digit_r       <= digit_next_s;
      snap_value_r  <= snap_value_next_s;
      snap_enable_r <= snap_enable_next_s;
    end
  end

`ifdef SIXTEEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0] snap_dp_r;

  // decimal-point snapshot, taken with the value snapshot
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      snap_dp_r <= '0;
    end else begin
      snap_dp_r <= snap_dp_next_s;
    end
  end

  assign snap_dp_s = snap_dp_r;
`else
  assign snap_dp_s = '0;
`endif

  // Output drive. A digit boundary either applies slot 0 at once or starts
  // the blank timer; the slot-0 bit then lands when the timer expires.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      segment_n_r    <= 16'hFFFF;
      segment_dp_n_r <= 1'b1;
      anode_r        <= NUM_DIGITS'(1);
      frame_start_r  <= 1'b0;
      blank_cnt_r    <= '0;
    end else begin
      frame_start_r <= digit_wrap_s;
      if (slot_wrap_s) begin
        anode_r <= anode_next_s;
      end
      if (dot_tick_s) begin
        if (slot_wrap_s && BLANK_EN) begin
          segment_n_r    <= 16'hFFFF;
          segment_dp_n_r <= 1'b1;
          blank_cnt_r    <= BLANK_W'(BLANK_CYCLES);
        end else begin
          {segment_dp_n_r, segment_n_r} <= tick_pat_s;
          blank_cnt_r                   <= '0;
        end
      end else if (blank_cnt_r != '0) begin
        blank_cnt_r <= blank_cnt_r - 1'b1;
        if (blank_cnt_r == BLANK_W'(1)) begin
          {segment_dp_n_r, segment_n_r} <= hold_pat_s;
        end
      end
    end
  end

  assign disp.segment_n    = segment_n_r;
  assign disp.segment_dp_n = segment_dp_n_r;
  assign disp.anode        = anode_r;
  assign disp.frame_start  = frame_start_r;

endmodule

// File: tb/tb_sixteen_segment_scan_driver.sv
// Bench for sixteen_segment_scan_driver: DOT_DIVIDE=4, NUM_DIGITS=2, one instance with
// BLANK_CYCLES=0 and one with BLANK_CYCLES=2, checked every cycle against an arithmetic model.
module tb_sixteen_segment_scan_driver;
  localparam int D  = 4;
  localparam int ND = 2;
`ifdef SIXTEEN_SEG_DP_EN
  localparam int NS        = 17;
  localparam int FRAME_LEN = 136;
  localparam bit DP_ON     = 1'b1;
`else
  localparam int NS        = 16;
  localparam int FRAME_LEN = 128;
  localparam bit DP_ON     = 1'b0;
`endif

  localparam logic [15:0] GLYPH_TB [16] = '{
    16'h00FF, 16'hCFFF, 16'h11E7, 16'h03E7, 16'hCEE7, 16'h22E7, 16'h20E7, 16'h0FFF,
    16'h00E7, 16'h02E7, 16'h0CE7, 16'hE0E7, 16'h30FF, 16'hC1E7, 16'h30E7, 16'h3CEF
  };

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] value = 8'h00;
  logic [1:0] enable = 2'b00;
  logic [1:0] dp = 2'b00;

  sixteen_segment_scan_driver_if #(.NUM_DIGITS(ND)) if0 ();
  sixteen_segment_scan_driver_if #(.NUM_DIGITS(ND)) if1 ();

  assign if0.value = value;
  assign if0.digit_enable = enable;
  assign if1.value = value;
  assign if1.digit_enable = enable;
`ifdef SIXTEEN_SEG_DP_EN
  assign if0.dp_in = dp;
  assign if1.dp_in = dp;
`endif

  sixteen_segment_scan_driver #(.NUM_DIGITS(ND), .DOT_DIVIDE(D), .BLANK_CYCLES(0)) dut0 (
    .CLK(CLK), .reset_n(reset_n), .disp(if0));
  sixteen_segment_scan_driver #(.NUM_DIGITS(ND), .DOT_DIVIDE(D), .BLANK_CYCLES(2)) dut1 (
    .CLK(CLK), .reset_n(reset_n), .disp(if1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: posedges since reset release, and the inputs sampled at each frame boundary
  int         edge_cnt;
  logic [7:0] m_val;
  logic [1:0] m_en;
  logic [1:0] m_dp;
  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= 0;
      m_val    <= 8'h00;
      m_en     <= 2'b00;
      m_dp     <= 2'b00;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (((edge_cnt + 1) % (D * NS * ND)) == 0) begin
        m_val <= value;
        m_en  <= enable;
        m_dp  <= dp;
      end
    end
  end

  function automatic void model(input int n, input int b, input logic [7:0] sv, input logic [1:0] se,
                                input logic [1:0] sd, output logic [15:0] seg, output logic dpn,
                                output logic [1:0] an, output logic fs);
    int k, m, slot, dig;
    logic [15:0] g;
    k    = n / D;
    m    = n % D;
    slot = k % NS;
    dig  = (k / NS) % ND;
    an   = 2'b01 << dig;
    fs   = (k > 0) && (m == 0) && ((k % (NS * ND)) == 0);
    seg  = 16'hFFFF;
    dpn  = 1'b1;
    g    = GLYPH_TB[(sv >> (4 * dig)) & 8'h0F];
    if (k > 0 && !(slot == 0 && m < b) && se[dig]) begin
      if (slot < 16) seg[15 - slot] = g[15 - slot];
      else dpn = ~sd[dig];
    end
  endfunction

  bit          chk_en = 1'b0;
  int          frame_cnt = 0;
  int          cyc = 0;
  int          last_fs_cyc = -1;
  logic [15:0] coll0 = 16'hFFFF, coll1 = 16'hFFFF, last0, last1;
  logic        colldp0 = 1'b1, colldp1 = 1'b1, lastdp0, lastdp1;

  // per-cycle monitor: compare both instances with the model and collect scanned glyphs
  initial begin
    logic [15:0] es;
    logic        ed, ef;
    logic [1:0]  ea;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!reset_n) last_fs_cyc = -1;
      if (chk_en) begin
        model(edge_cnt, 0, m_val, m_en, m_dp, es, ed, ea, ef);
        check("seg0", if0.segment_n, es);
        check("dp0", if0.segment_dp_n, ed);
        check("anode0", if0.anode, ea);
        check("fstart0", if0.frame_start, ef);
        check("single_low0", ($countones({if0.segment_dp_n, if0.segment_n}) >= 16), 1);
        model(edge_cnt, 2, m_val, m_en, m_dp, es, ed, ea, ef);
        check("seg1", if1.segment_n, es);
        check("dp1", if1.segment_dp_n, ed);
        check("anode1", if1.anode, ea);
        check("fstart1", if1.frame_start, ef);
        check("single_low1", ($countones({if1.segment_dp_n, if1.segment_n}) >= 16), 1);
        if (if0.frame_start) begin
          if (last_fs_cyc >= 0) check("frame_len", cyc - last_fs_cyc, FRAME_LEN);
          last_fs_cyc = cyc;
          last0 = coll0; last1 = coll1; lastdp0 = colldp0; lastdp1 = colldp1;
          coll0 = 16'hFFFF; coll1 = 16'hFFFF; colldp0 = 1'b1; colldp1 = 1'b1;
          frame_cnt++;
        end
        if (if0.anode[0]) begin coll0 &= if0.segment_n; colldp0 &= if0.segment_dp_n; end
        if (if0.anode[1]) begin coll1 &= if0.segment_n; colldp1 &= if0.segment_dp_n; end
      end
    end
  end

  task automatic wait_frames(input int nf);
    int target = frame_cnt + nf;
    int budget = (nf + 2) * FRAME_LEN;
    while (frame_cnt < target && budget > 0) begin
      @(negedge CLK); #2;
      budget--;
    end
    check("frame_wait", (frame_cnt >= target), 1);
  endtask

  typedef struct {
    logic [7:0]  value;
    logic [1:0]  en;
    logic [1:0]  dp;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [1:0]  exp_dpn;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [1:0] an_prev;
    int         budget;

    vecs[0] = '{8'h08, 2'b11, 2'b01, 16'h00E7, 16'h00FF, 2'b11};
    vecs[1] = '{8'h10, 2'b11, 2'b10, 16'h00FF, 16'hCFFF, 2'b11};
    vecs[2] = '{8'h08, 2'b10, 2'b11, 16'hFFFF, 16'h00FF, 2'b11};
    vecs[3] = '{8'hF1, 2'b11, 2'b11, 16'hCFFF, 16'h3CEF, 2'b11};
    vecs[4] = '{8'h8F, 2'b01, 2'b11, 16'h3CEF, 16'hFFFF, 2'b11};
    vecs[5] = '{8'h00, 2'b00, 2'b01, 16'hFFFF, 16'hFFFF, 2'b11};
    foreach (vecs[i]) if (DP_ON) vecs[i].exp_dpn = ~(vecs[i].dp & vecs[i].en);

    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("reset_seg", if0.segment_n, 16'hFFFF);
    check("reset_anode", if0.anode, 2'b01);
    reset_n = 1'b1;

    // table: each entry takes effect one frame after it is applied
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      value = vecs[i].value; enable = vecs[i].en; dp = vecs[i].dp;
      wait_frames(2);
      check($sformatf("glyph0_v%0d", i), last0, vecs[i].exp0);
      check($sformatf("glyph1_v%0d", i), last1, vecs[i].exp1);
      check($sformatf("dpn0_v%0d", i), lastdp0, vecs[i].exp_dpn[0]);
      check($sformatf("dpn1_v%0d", i), lastdp1, vecs[i].exp_dpn[1]);
    end

    // mid-frame value change stays invisible until the next frame
    @(negedge CLK); value = 8'h08; enable = 2'b11; dp = 2'b00;
    wait_frames(1);
    repeat (10) @(negedge CLK);
    value = 8'h10;
    wait_frames(1);
    check("midframe_old0", last0, 16'h00E7);
    check("midframe_old1", last1, 16'h00FF);
    wait_frames(1);
    check("midframe_new0", last0, 16'h00FF);
    check("midframe_new1", last1, 16'hCFFF);

    // blanking: two dark cycles after each anode change, then segment a
    @(negedge CLK); value = 8'h08;
    wait_frames(2);
    an_prev = if1.anode;
    budget = 4 * NS * D;
    while (if1.anode == an_prev && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check("blank_anode_change", (if1.anode != an_prev), 1);
    check("blank_c0", if1.segment_n, 16'hFFFF);
    @(negedge CLK);
    check("blank_c1", if1.segment_n, 16'hFFFF);
    @(negedge CLK);
    check("blank_bit_a", if1.segment_n, 16'h7FFF);

    // randomized inputs, changed at arbitrary points in the frame
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      value = 8'($urandom); enable = 2'($urandom); dp = 2'($urandom);
      repeat ($urandom_range(1, 60)) @(negedge CLK);
    end

    // asynchronous reset mid-scan: outputs return before any clock edge
    wait_frames(1);
    repeat (37) @(negedge CLK);
    @(posedge CLK); #2;
    reset_n = 1'b0;
    #1;
    check("arst_seg0", if0.segment_n, 16'hFFFF);
    check("arst_anode0", if0.anode, 2'b01);
    check("arst_fs0", if0.frame_start, 1'b0);
    check("arst_dp0", if0.segment_dp_n, 1'b1);
    check("arst_seg1", if1.segment_n, 16'hFFFF);
    check("arst_anode1", if1.anode, 2'b01);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK); value = 8'hF1; enable = 2'b11;
    wait_frames(2);
    check("post_reset_glyph0", last0, 16'hCFFF);
    check("post_reset_glyph1", last1, 16'h3CEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
